// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - MIPS next-PC select with EPC capture and a JAL/JR return-address stack
module pc_next_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'('h80),
  parameter int                RAS_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pc_write,
  input  logic [2:0]        i_pc_source,
  input  logic              i_zero,
  input  logic              i_neg,
  input  logic              i_exc_req,
  input  logic              i_is_link,
  input  logic [ADDR_W-1:0] i_seq_addr,
  input  logic [ADDR_W-1:0] i_branch_addr,
  input  logic [ADDR_W-1:0] i_jump_addr,
  input  logic [ADDR_W-1:0] i_reg_addr,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_epc,
  output logic              o_taken,
  output logic              o_last_taken,
  output logic              o_align_err,
  output logic              o_ras_mismatch,
  output logic [ADDR_W-1:0] o_ras_top,
  output logic              o_ras_empty,
  output logic              o_ras_full
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] SRC_BEQ  = 3'b001;
  localparam logic [2:0] SRC_BNE  = 3'b010;
  localparam logic [2:0] SRC_J    = 3'b011;
  localparam logic [2:0] SRC_JR   = 3'b100;
  localparam logic [2:0] SRC_BLEZ = 3'b101;
  localparam logic [2:0] SRC_BGTZ = 3'b110;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_epc;
  logic              r_last_taken;
  logic              r_align_err;
  logic              r_ras_mismatch;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic [CNT_W-1:0]  r_cnt;

  logic [ADDR_W-1:0] w_target;
  logic              w_taken;
  logic              w_misalign;
  logic              w_exc;
  logic              w_trap;
  logic              w_commit;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [PTR_W-1:0]  w_top_idx;
  logic [ADDR_W-1:0] w_top;

  always_comb begin
    w_target = i_seq_addr;
    w_taken  = 1'b0;
    case (i_pc_source)
      SRC_BEQ:  if (i_zero)           begin w_target = i_branch_addr; w_taken = 1'b1; end
      SRC_BNE:  if (!i_zero)          begin w_target = i_branch_addr; w_taken = 1'b1; end
      SRC_BLEZ: if (i_neg || i_zero)  begin w_target = i_branch_addr; w_taken = 1'b1; end
      SRC_BGTZ: if (!i_neg && !i_zero) begin w_target = i_branch_addr; w_taken = 1'b1; end
      SRC_J:    begin w_target = i_jump_addr; w_taken = 1'b1; end
      SRC_JR:   begin w_target = i_reg_addr;  w_taken = 1'b1; end
      default:  ;
    endcase
  end

  // Exceptions outrank alignment traps; neither touches the RAS.
  assign w_misalign = (w_target[1:0] != 2'b00);
  assign w_exc      = i_pc_write && i_exc_req;
  assign w_trap     = i_pc_write && !i_exc_req && w_misalign;
  assign w_commit   = i_pc_write && !i_exc_req && !w_misalign;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_top_idx = r_sp - PTR_W'(1);
  assign w_top     = w_empty ? '0 : r_ras[w_top_idx];

  assign w_push = w_commit && (i_pc_source == SRC_J) && i_is_link;
  assign w_pop  = w_commit && (i_pc_source == SRC_JR) && !w_empty;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc           <= RESET_VEC;
      r_epc          <= '0;
      r_last_taken   <= 1'b0;
      r_align_err    <= 1'b0;
      r_ras_mismatch <= 1'b0;
      r_sp           <= '0;
      r_cnt          <= '0;
    end else begin
      r_align_err    <= 1'b0;
      r_ras_mismatch <= 1'b0;
      if (i_pc_write) begin
        r_last_taken <= w_taken;
        if (w_exc || w_trap) begin
          r_pc  <= EXC_VEC;
          r_epc <= r_pc;
        end else begin
          r_pc <= w_target;
        end
        r_align_err <= w_trap;
      end
      // Stack pointer wraps, so a push when full overwrites the oldest entry.
      if (w_push) begin
        r_sp <= r_sp + PTR_W'(1);
        if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_sp           <= w_top_idx;
        r_cnt          <= r_cnt - CNT_W'(1);
        r_ras_mismatch <= (w_top != i_reg_addr);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) r_ras[r_sp] <= i_seq_addr;
  end

  assign o_pc           = r_pc;
  assign o_epc          = r_epc;
  assign o_taken        = w_taken;
  assign o_last_taken   = r_last_taken;
  assign o_align_err    = r_align_err;
  assign o_ras_mismatch = r_ras_mismatch;
  assign o_ras_top      = w_top;
  assign o_ras_empty    = w_empty;
  assign o_ras_full     = w_full;

endmodule
